ccff_chain_loader: RTL and testbench

- Upstream configuration stage for a chain of logical tiles (frac_logic / frac_lut4 plus mux_tree memories).
- Accepts configuration bitstream bytes over a valid/ready handshake and serialises them onto the tiles' ccff_head input, one bit per enabled prog_clk edge.
- Before the data it shifts an 8-bit sentinel, then checks that the sentinel emerges on ccff_tail after exactly CHAIN_LEN shifts. This confirms chain continuity and length.
- Drives ccff_en, which gates the chain's prog_clk at integration.

---
 rtl/ccff_loader_pkg.sv | 18 +
 rtl/ccff_byte_serializer.sv | 92 +++++++++
 rtl/ccff_chain_loader.sv | 122 ++++++++++++
 tb/tb_ccff_chain_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSent = 2'd1,
        StLoad = 2'd2,
        StDone = 2'd3
    } state_e;

    localparam logic [7:0] DEFAULT_SENTINEL = 8'hA5;

    // Number of bitstream bytes needed to fill chain_len flops.
    function automatic int unsigned words_required(input int unsigned chain_len);
        return (chain_len + 7) / 8;
    endfunction

endpackage

// File: rtl/ccff_byte_serializer.sv
// One-byte buffer that hands bitstream bytes out one bit per shift, LSB first.
// The final word only contributes its low (CHAIN_LEN mod 8, or 8) bits.
module ccff_byte_serializer
    import ccff_loader_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 20
) (
    input  logic       prog_clk,
    input  logic       pReset,
    input  logic       clear_i,
    input  logic       fetch_en_i,
    input  logic       shift_en_i,
    input  logic [7:0] word_data_i,
    input  logic       word_valid_i,
    output logic       word_ready_o,
    output logic       bit_valid_o,
    output logic       bit_o
);

    localparam int unsigned Words    = words_required(CHAIN_LEN);
    localparam int unsigned LastBits = ((CHAIN_LEN % 8) == 0) ? 8 : (CHAIN_LEN % 8);
    localparam logic [2:0]  LastIdx  = 3'(LastBits - 1);
    localparam logic [15:0] WordsInit = 16'(Words);

    logic [7:0]  buf_q, buf_d;
    logic        buf_valid_q, buf_valid_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        is_last_q, is_last_d;
    logic [15:0] words_left_q, words_left_d;

    logic [2:0] last_idx;
    logic       last_bit;
    logic       accept;

    // Ready/last-bit decode and next-state of the buffer.
    always_comb begin
        last_idx     = is_last_q ? LastIdx : 3'd7;
        last_bit     = buf_valid_q && shift_en_i && (bit_idx_q == last_idx);
        word_ready_o = fetch_en_i && (words_left_q != 16'd0) && (!buf_valid_q || last_bit);
        accept       = word_ready_o && word_valid_i;
        bit_valid_o  = buf_valid_q;
        bit_o        = buf_q[bit_idx_q];

        buf_d        = buf_q;
        buf_valid_d  = buf_valid_q;
        bit_idx_d    = bit_idx_q;
        is_last_d    = is_last_q;
        words_left_d = words_left_q;

        if (clear_i) begin
            words_left_d = WordsInit;
            buf_valid_d  = 1'b0;
            bit_idx_d    = 3'd0;
            is_last_d    = 1'b0;
        end else begin
            if (shift_en_i && buf_valid_q) begin
                if (last_bit) begin
                    buf_valid_d = 1'b0;
                    bit_idx_d   = 3'd0;
                end else begin
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            // A new word may land on the same edge the old one empties: no bubble.
            if (accept) begin
                buf_d        = word_data_i;
                buf_valid_d  = 1'b1;
                bit_idx_d    = 3'd0;
                is_last_d    = (words_left_q == 16'd1);
                words_left_d = words_left_q - 16'd1;
            end
        end
    end

    // Buffer state registers.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            buf_q        <= 8'd0;
            buf_valid_q  <= 1'b0;
            bit_idx_q    <= 3'd0;
            is_last_q    <= 1'b0;
            words_left_q <= 16'd0;
        end else begin
            buf_q        <= buf_d;
            buf_valid_q  <= buf_valid_d;
            bit_idx_q    <= bit_idx_d;
            is_last_q    <= is_last_d;
            words_left_q <= words_left_d;
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads a configuration chain: shifts a sentinel then the bitstream, and
// checks that the sentinel reappears on ccff_tail after CHAIN_LEN shifts.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 20,
    parameter logic [7:0]  SENTINEL  = DEFAULT_SENTINEL
) (
    input  logic       prog_clk,
    input  logic       pReset,
    input  logic       start,
    input  logic [7:0] word_data,
    input  logic       word_valid,
    output logic       word_ready,
    output logic       ccff_head,
    input  logic       ccff_tail,
    output logic       ccff_en,
    output logic       busy,
    output logic       done,
    output logic       chain_ok,
    output logic       err
);

    // One bit wider than 16 so 8+CHAIN_LEN-1 fits at the maximum chain length.
    localparam logic [16:0] ScFirst = 17'(CHAIN_LEN);
    localparam logic [16:0] ScLast  = 17'(CHAIN_LEN + 7);

    state_e      state_q, state_d;
    logic [16:0] sc_q, sc_d;
    logic        mismatch_q, mismatch_d;
    logic        err_q, err_d;

    logic        start_load;
    logic        fetch_en;
    logic        ser_valid;
    logic        ser_bit;
    logic [16:0] win_off;

    ccff_byte_serializer #(
        .CHAIN_LEN (CHAIN_LEN)
    ) u_ser (
        .prog_clk     (prog_clk),
        .pReset       (pReset),
        .clear_i      (start_load),
        .fetch_en_i   (fetch_en),
        .shift_en_i   (state_q == StLoad),
        .word_data_i  (word_data),
        .word_valid_i (word_valid),
        .word_ready_o (word_ready),
        .bit_valid_o  (ser_valid),
        .bit_o        (ser_bit)
    );

    // Fetch the first word during the last sentinel bit so data follows without a gap.
    assign fetch_en = (state_q == StLoad) || ((state_q == StSent) && (sc_q == 17'd7));

    // FSM next-state, shift counter, tail comparator and outputs.
    always_comb begin
        state_d    = state_q;
        sc_d       = sc_q;
        mismatch_d = mismatch_q;
        err_d      = err_q;
        start_load = 1'b0;
        ccff_en    = 1'b0;
        ccff_head  = 1'b0;
        win_off    = sc_q - ScFirst;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d    = StSent;
                    sc_d       = 17'd0;
                    mismatch_d = 1'b0;
                    err_d      = 1'b0;
                    start_load = 1'b1;
                end
            end
            StSent: begin
                ccff_en   = 1'b1;
                ccff_head = SENTINEL[sc_q[2:0]];
                sc_d      = sc_q + 17'd1;
                if (sc_q == 17'd7) state_d = StLoad;
                if (start) err_d = 1'b1;
            end
            StLoad: begin
                ccff_en   = ser_valid;
                ccff_head = ser_valid ? ser_bit : 1'b0;
                if (ser_valid) begin
                    sc_d = sc_q + 17'd1;
                    if (sc_q == ScLast) state_d = StDone;
                end
                if (start) err_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        if (ccff_en && (sc_q >= ScFirst) && (sc_q <= ScLast)) begin
            if (ccff_tail != SENTINEL[win_off[2:0]]) mismatch_d = 1'b1;
        end

        busy     = (state_q == StSent) || (state_q == StLoad);
        done     = (state_q == StDone);
        chain_ok = (state_q == StDone) && !mismatch_q;
        err      = err_q;
    end

    // Control state registers.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q    <= StIdle;
            sc_q       <= 17'd0;
            mismatch_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sc_q       <= sc_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with a behavioural model of the chain.
module tb_ccff_chain_loader;

    logic       prog_clk = 1'b0;
    logic       pReset   = 1'b1;
    logic       start    = 1'b0;
    logic [7:0] word_data = 8'd0;
    logic       word_valid = 1'b0;
    logic       word_ready, ccff_head, ccff_tail, ccff_en, busy, done, chain_ok, err;

    logic       start2 = 1'b0;
    logic [7:0] word_data2 = 8'd0;
    logic       word_valid2 = 1'b0;
    logic       word_ready2, ccff_head2, ccff_tail2, ccff_en2, busy2, done2, chain_ok2, err2;

    int total = 0;
    int bad   = 0;

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader #(.CHAIN_LEN(20), .SENTINEL(8'hA5)) dut (
        .prog_clk   (prog_clk),
        .pReset     (pReset),
        .start      (start),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .ccff_head  (ccff_head),
        .ccff_tail  (ccff_tail),
        .ccff_en    (ccff_en),
        .busy       (busy),
        .done       (done),
        .chain_ok   (chain_ok),
        .err        (err)
    );

    ccff_chain_loader #(.CHAIN_LEN(8), .SENTINEL(8'hA5)) dut8 (
        .prog_clk   (prog_clk),
        .pReset     (pReset),
        .start      (start2),
        .word_data  (word_data2),
        .word_valid (word_valid2),
        .word_ready (word_ready2),
        .ccff_head  (ccff_head2),
        .ccff_tail  (ccff_tail2),
        .ccff_en    (ccff_en2),
        .busy       (busy2),
        .done       (done2),
        .chain_ok   (chain_ok2),
        .err        (err2)
    );

    // Chain models: first-shifted bit ends up at bit 0; the short variant taps one flop early.
    logic [19:0] chain = 20'd0;
    logic [7:0]  chain8 = 8'd0;
    logic        short_chain = 1'b0;
    always @(posedge prog_clk) if (ccff_en) chain <= {ccff_head, chain[19:1]};
    always @(posedge prog_clk) if (ccff_en2) chain8 <= {ccff_head2, chain8[7:1]};
    assign ccff_tail  = short_chain ? chain[1] : chain[0];
    assign ccff_tail2 = chain8[0];

    logic [7:0] words [3] = '{8'h3C, 8'h81, 8'h0F};

    typedef struct {
        string       name;
        bit          short_c;
        int          gap;
        bit          busy_start;
        int          exp_low;
        logic [19:0] exp_chain;
        bit          exp_ok;
        bit          exp_err;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_load(input bit short_c, input int gap, input bit busy_start,
                            output int en_n, output int low_n, output logic [27:0] heads,
                            output int acc_n, output bit timed_out);
        int  idx;
        int  gap_left;
        bit  seen;
        short_chain = short_c;
        idx = 0; gap_left = gap; en_n = 0; low_n = 0; heads = '0; acc_n = 0; seen = 0;
        timed_out = 1'b1;
        @(negedge prog_clk); start = 1'b1;
        @(negedge prog_clk); start = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            start      = busy_start && (en_n == 14);
            word_valid = (idx < 3);
            word_data  = (idx < 3) ? words[idx] : 8'd0;
            if (idx == 1 && gap_left > 0 && word_ready) begin
                word_valid = 1'b0;
                gap_left--;
            end
            #1;
            if (ccff_en) begin
                if (en_n < 28) heads[en_n] = ccff_head;
                en_n++;
                seen = 1;
            end else if (seen) begin
                low_n++;
            end
            if (word_valid && word_ready) begin
                acc_n++;
                idx++;
            end
            @(negedge prog_clk);
        end
        start = 1'b0;
        word_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          en_n, low_n, acc_n, shifts, idx, guard;
        logic [27:0] heads;
        bit          to;

        vecs[0] = '{"nominal",   1'b0, 0, 1'b0, 0, 20'hF813C, 1'b1, 1'b0};
        vecs[1] = '{"backpress", 1'b0, 5, 1'b0, 5, 20'hF813C, 1'b1, 1'b0};
        vecs[2] = '{"short",     1'b1, 0, 1'b0, 0, 20'hF813C, 1'b0, 1'b0};
        vecs[3] = '{"busystart", 1'b0, 0, 1'b1, 0, 20'hF813C, 1'b1, 1'b1};

        #12;
        check("reset_outputs", {word_ready, ccff_head, ccff_en, busy, done, chain_ok, err}, 7'd0);
        @(negedge prog_clk); pReset = 1'b0;

        for (int v = 0; v < 4; v++) begin
            run_load(vecs[v].short_c, vecs[v].gap, vecs[v].busy_start, en_n, low_n, heads, acc_n, to);
            check({vecs[v].name, "_timeout"}, to, 1'b0);
            check({vecs[v].name, "_en_count"}, en_n, 28);
            check({vecs[v].name, "_en_low"}, low_n, vecs[v].exp_low);
            check({vecs[v].name, "_heads"}, heads, 28'hF813CA5);
            check({vecs[v].name, "_words"}, acc_n, 3);
            check({vecs[v].name, "_chain"}, chain, vecs[v].exp_chain);
            check({vecs[v].name, "_done"}, {done, busy}, 2'b10);
            check({vecs[v].name, "_chain_ok"}, chain_ok, vecs[v].exp_ok);
            check({vecs[v].name, "_err"}, err, vecs[v].exp_err);
        end
        short_chain = 1'b0;

        // Start from DONE clears the sticky error.
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        check("restart_err_clear", {err, busy, done}, 3'b010);

        // Reset in the middle of a load, at sc=12.
        shifts = 0; idx = 0; guard = 0;
        @(negedge prog_clk);
        while (shifts < 12 && guard < 100) begin
            word_valid = (idx < 3);
            word_data  = (idx < 3) ? words[idx] : 8'd0;
            #1;
            if (ccff_en) shifts++;
            if (word_valid && word_ready) idx++;
            guard++;
            @(negedge prog_clk);
        end
        check("midload_reached", shifts, 12);
        pReset = 1'b1;
        #1;
        check("midload_reset_out", {word_ready, ccff_head, ccff_en, busy, done, chain_ok, err}, 7'd0);
        word_valid = 1'b0;
        @(negedge prog_clk); pReset = 1'b0;
        run_load(1'b0, 0, 1'b0, en_n, low_n, heads, acc_n, to);
        check("after_reset_timeout", to, 1'b0);
        check("after_reset_en", en_n, 28);
        check("after_reset_chain", chain, 20'hF813C);
        check("after_reset_ok", {done, chain_ok}, 2'b11);

        // CHAIN_LEN=8 with a single 0xFF word.
        en_n = 0; acc_n = 0; to = 1'b1;
        @(negedge prog_clk); start2 = 1'b1;
        @(negedge prog_clk); start2 = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (done2) begin
                to = 1'b0;
                break;
            end
            word_valid2 = 1'b1;
            word_data2  = 8'hFF;
            #1;
            if (ccff_en2) en_n++;
            if (word_valid2 && word_ready2) acc_n++;
            @(negedge prog_clk);
        end
        word_valid2 = 1'b0;
        check("len8_timeout", to, 1'b0);
        check("len8_en", en_n, 16);
        check("len8_words", acc_n, 1);
        check("len8_chain", chain8, 8'hFF);
        check("len8_ok", {done2, chain_ok2, err2}, 3'b110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
